mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Shares the single external memory bus between the instruction-fetch (IF) and data-memory (MEM) stages of the MIPS pipeline. It registers a winning request onto the bus and drives the select of the bus address/data multiplexers. It returns read data and a one-cycle ready pulse to the owning requester, and raises the pipeline stall while any request is outstanding. MEM has fixed priority over IF.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width (byte enables are DATA_W/8 bits)

- W_clk  in  1  clock, all state on rising edge
- W_rst_n  in  1  asynchronous, active-low reset
- W_if_req  in  1  IF request, level, held until W_if_ready
- W_if_addr  in  ADDR_W  IF address (read only)
- W_if_flush  in  1  pulse, discard in-flight IF result
- W_if_rdata  out  DATA_W  IF read data, registered
- W_if_ready  out  1  one-cycle pulse, IF data valid
- W_mem_req  in  1  MEM request, level, held until W_mem_ready
- W_mem_we  in  1  1 = write
- W_mem_be  in  DATA_W/8  byte enables
- W_mem_addr  in  ADDR_W  MEM address
- W_mem_wdata  in  DATA_W  write data
- W_mem_rdata  out  DATA_W  MEM read data, registered
- W_mem_ready  out  1  one-cycle pulse, MEM access complete
- W_bus_req  out  1  bus request, held until W_bus_ack
- W_bus_sel  out  1  0 = IF owns bus, 1 = MEM owns bus (drives bus mux select)
- W_bus_we, W_bus_be, W_bus_addr, W_bus_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  registered bus command
- W_bus_ack  in  1  slave completion, one cycle
- W_bus_rdata  in  DATA_W  valid in the W_bus_ack cycle
- W_stall  out  1  pipeline stall

## Operation
- FSM states: IDLE, GNT_IF, GNT_MEM.
- Request masking: a requester's req is ignored in any cycle where its own ready is high. This covers the cycle in which it is dropping req.
- IDLE transitions:
  - Unmasked W_mem_req → GNT_MEM. Latch we/be/addr/wdata onto the bus outputs; W_bus_sel=1.
  - Else unmasked W_if_req → GNT_IF. Latch addr; we=0, be=all ones, wdata=0; W_bus_sel=0.
  - Else stay in IDLE.
- GNT_x: W_bus_req=1 and the bus command stays stable until W_bus_ack.
- On W_bus_ack:
  - Capture W_bus_rdata into x's rdata register. MEM writes also capture it; the value is don't-care to the core.
  - Pulse x's ready next cycle.
  - Return to IDLE.
- W_bus_ack in IDLE is ignored and has no effect on state or outputs.
- Flush:
  - W_if_flush in GNT_IF, up to and including the ack cycle, sets a drop flag.
  - The bus transaction still completes, but W_if_rdata is not updated and W_if_ready is not pulsed.
  - The drop flag clears on return to IDLE.
  - W_if_flush in IDLE or GNT_MEM has no effect.
- W_stall = (W_if_req & ~W_if_ready) | (W_mem_req & ~W_mem_ready). This is combinational and is the only combinational output.
- W_bus_sel holds its last value in IDLE.

## Timing
- Reset values (async, immediate): state IDLE. W_bus_req=0, W_bus_sel=0, W_bus_we=0, W_bus_be=0, W_bus_addr=0, W_bus_wdata=0. W_if_ready=0, W_mem_ready=0, W_if_rdata=0, W_mem_rdata=0. Drop flag cleared.
- Reset mid-transaction abandons it: no ready pulse, W_bus_req drops immediately.
- Latency:
  - Request sampled at edge N (state IDLE) → W_bus_req high in cycle N+1.
  - Ack in cycle K → ready high in cycle K+1, state IDLE in K+1.
  - Zero-wait slave: req at N gives ready at N+2.
- Back-to-back: the ready cycle K+1 is an IDLE cycle and may grant the other requester. Its W_bus_req rises at K+2.
- Simultaneous W_if_req and W_mem_req in IDLE: MEM is granted first and IF waits. IF is served in the following IDLE because MEM is masked during its ready cycle.
- Bus command outputs change only on IDLE→GNT transitions.

## Test plan
- Zero-wait slave (ack in the first W_bus_req cycle), IF read of addr 0x0040_0000 with rdata 0x2402_000A → W_bus_sel=0, W_if_ready pulses 2 cycles after req, W_if_rdata=0x2402_000A, W_mem_ready never pulses.
- Slave ack delay 3 cycles, MEM write addr 0x1001_0004, be 4'b0011, wdata 0xDEAD_BEEF → bus command stable for 3 cycles with W_bus_sel=1, W_stall high until the W_mem_ready cycle, single ready pulse.
- IF and MEM requests rise in the same cycle → MEM granted first. IF W_bus_req rises 2 cycles after MEM ack. Exactly one ready pulse each, in MEM-then-IF order.
- W_if_flush asserted mid-way through a 2-cycle IF transaction → ack consumed, no W_if_ready, W_if_rdata unchanged, FSM back in IDLE.
- W_rst_n pulled low during GNT_MEM → W_bus_req and all outputs reset in the same cycle. After release with no requests, state stays IDLE, and a stray W_bus_ack is ignored.
- Requester holds req during its ready cycle → no second bus transaction issued.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one external memory bus between the instruction-fetch (IF) and
// data-memory (MEM) pipeline stages. MEM has fixed priority over IF. A winning
// request is registered onto the bus command outputs. Completion returns read
// data plus a one-cycle ready pulse to the owner. The pipeline stall stays high
// while any request is outstanding.
//
// Ports
//   W_clk, W_rst_n          clock (rising edge), async active-low reset
//   W_if_req/addr/flush     IF read request (level), address, result discard
//   W_if_rdata/ready        IF read data (registered), one-cycle done pulse
//   W_mem_req/we/be/addr/wdata
//                           MEM request (level) and its command
//   W_mem_rdata/ready       MEM read data (registered), one-cycle done pulse
//   W_bus_req/sel           bus request, bus-mux select (0 = IF, 1 = MEM)
//   W_bus_we/be/addr/wdata  registered bus command, stable while W_bus_req
//   W_bus_ack, W_bus_rdata  slave completion and read data (same cycle)
//   W_stall                 combinational pipeline stall
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic                  W_clk,
   input  logic                  W_rst_n,
   // instruction-fetch port
   input  logic                  W_if_req,
   input  logic [ADDR_W-1:0]     W_if_addr,
   input  logic                  W_if_flush,
   output logic [DATA_W-1:0]     W_if_rdata,
   output logic                  W_if_ready,
   // data-memory port
   input  logic                  W_mem_req,
   input  logic                  W_mem_we,
   input  logic [DATA_W/8-1:0]   W_mem_be,
   input  logic [ADDR_W-1:0]     W_mem_addr,
   input  logic [DATA_W-1:0]     W_mem_wdata,
   output logic [DATA_W-1:0]     W_mem_rdata,
   output logic                  W_mem_ready,
   // external bus
   output logic                  W_bus_req,
   output logic                  W_bus_sel,
   output logic                  W_bus_we,
   output logic [DATA_W/8-1:0]   W_bus_be,
   output logic [ADDR_W-1:0]     W_bus_addr,
   output logic [DATA_W-1:0]     W_bus_wdata,
   input  logic                  W_bus_ack,
   input  logic [DATA_W-1:0]     W_bus_rdata,
   // pipeline
   output logic                  W_stall
);

   localparam int unsigned BE_W = DATA_W / 8;

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] GNT_IF  = 2'd1;
   localparam logic [1:0] GNT_MEM = 2'd2;

   // Registered bus command payload
   typedef struct packed {
      logic              we;
      logic [BE_W-1:0]   be;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } bus_cmd_t;

   logic [1:0]        state_q,     state_nxt;
   logic              bus_req_q,   bus_req_nxt;
   logic              bus_sel_q,   bus_sel_nxt;
   bus_cmd_t          cmd_q,       cmd_nxt;
   logic [DATA_W-1:0] if_rdata_q,  if_rdata_nxt;
   logic              if_ready_q,  if_ready_nxt;
   logic [DATA_W-1:0] mem_rdata_q, mem_rdata_nxt;
   logic              mem_ready_q, mem_ready_nxt;
   logic              drop_q,      drop_nxt;

   // A requester is masked in its own ready cycle, where it may still hold req
   logic if_req_live;
   logic mem_req_live;
   logic if_discard;

   assign if_req_live  = W_if_req  & ~if_ready_q;
   assign mem_req_live = W_mem_req & ~mem_ready_q;

   // Flush seen earlier in the grant, or in the ack cycle itself
   assign if_discard   = drop_q | W_if_flush;

   // State register and all registered outputs
   always_ff @(posedge W_clk or negedge W_rst_n) begin
      if (!W_rst_n) begin
         state_q     <= IDLE;
         bus_req_q   <= 1'b0;
         bus_sel_q   <= 1'b0;
         cmd_q       <= '0;
         if_rdata_q  <= '0;
         if_ready_q  <= 1'b0;
         mem_rdata_q <= '0;
         mem_ready_q <= 1'b0;
         drop_q      <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         bus_req_q   <= bus_req_nxt;
         bus_sel_q   <= bus_sel_nxt;
         cmd_q       <= cmd_nxt;
         if_rdata_q  <= if_rdata_nxt;
         if_ready_q  <= if_ready_nxt;
         mem_rdata_q <= mem_rdata_nxt;
         mem_ready_q <= mem_ready_nxt;
         drop_q      <= drop_nxt;
      end
   end

   // Next-state and next-output logic
   always_comb begin
      state_nxt     = state_q;
      bus_req_nxt   = bus_req_q;
      bus_sel_nxt   = bus_sel_q;
      cmd_nxt       = cmd_q;
      if_rdata_nxt  = if_rdata_q;
      if_ready_nxt  = 1'b0;
      mem_rdata_nxt = mem_rdata_q;
      mem_ready_nxt = 1'b0;
      drop_nxt      = drop_q;

      case (state_q)
         IDLE: begin
            drop_nxt = 1'b0;
            if (mem_req_live) begin
               state_nxt     = GNT_MEM;
               bus_req_nxt   = 1'b1;
               bus_sel_nxt   = 1'b1;
               cmd_nxt.we    = W_mem_we;
               cmd_nxt.be    = W_mem_be;
               cmd_nxt.addr  = W_mem_addr;
               cmd_nxt.wdata = W_mem_wdata;
            end else if (if_req_live) begin
               state_nxt     = GNT_IF;
               bus_req_nxt   = 1'b1;
               bus_sel_nxt   = 1'b0;
               cmd_nxt.we    = 1'b0;
               cmd_nxt.be    = '1;
               cmd_nxt.addr  = W_if_addr;
               cmd_nxt.wdata = '0;
            end
         end

         GNT_IF: begin
            if (W_if_flush) begin
               drop_nxt = 1'b1;
            end
            if (W_bus_ack) begin
               state_nxt   = IDLE;
               bus_req_nxt = 1'b0;
               drop_nxt    = 1'b0;
               if (!if_discard) begin
                  if_rdata_nxt = W_bus_rdata;
                  if_ready_nxt = 1'b1;
               end
            end
         end

         GNT_MEM: begin
            // Write completions also capture the bus data; the core ignores it
            if (W_bus_ack) begin
               state_nxt     = IDLE;
               bus_req_nxt   = 1'b0;
               mem_rdata_nxt = W_bus_rdata;
               mem_ready_nxt = 1'b1;
            end
         end

         default: begin
            state_nxt   = IDLE;
            bus_req_nxt = 1'b0;
            drop_nxt    = 1'b0;
         end
      endcase
   end

   assign W_bus_req   = bus_req_q;
   assign W_bus_sel   = bus_sel_q;
   assign W_bus_we    = cmd_q.we;
   assign W_bus_be    = cmd_q.be;
   assign W_bus_addr  = cmd_q.addr;
   assign W_bus_wdata = cmd_q.wdata;
   assign W_if_rdata  = if_rdata_q;
   assign W_if_ready  = if_ready_q;
   assign W_mem_rdata = mem_rdata_q;
   assign W_mem_ready = mem_ready_q;

   // Only combinational output
   assign W_stall = (W_if_req & ~if_ready_q) | (W_mem_req & ~mem_ready_q);

endmodule
